regfile_wb_arbiter: RTL
=======================

# regfile_wb_arbiter

Write-port arbiter and scoreboard for the 32x32 integer register bank. It takes writeback beats from two independent sources, the ALU path and the load/memory path, and buffers each in a small FIFO. It round-robins them onto the bank's single write port (`rf_we`/`rf_waddr`/`rf_wdata`). It also tracks pending destination registers so the issue stage can stall on RAW hazards.

## Interface
Parameters:
- `DATA_W`, 32: writeback data width.
- `ADDR_W`, 5: register address width.
- `FIFO_DEPTH`, 2: entries per source FIFO; a power of two ≥ 2.

Ports:
- `clk`, input, 1: single clock; everything is on the rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `alu_valid`, input, 1: ALU writeback beat is present.
- `alu_ready`, output, 1: ALU FIFO not full.
- `alu_rd`, input, `ADDR_W`: ALU destination register.
- `alu_data`, input, `DATA_W`: ALU result.
- `mem_valid`, input, 1: load writeback beat is present.
- `mem_ready`, output, 1: MEM FIFO not full.
- `mem_rd`, input, `ADDR_W`: load destination register.
- `mem_data`, input, `DATA_W`: load data.
- `issue_valid`, input, 1: an instruction writing `issue_rd` issues this cycle.
- `issue_rd`, input, `ADDR_W`: destination register being marked pending.
- `rs1_addr`, input, `ADDR_W`: source register 1 being checked.
- `rs2_addr`, input, `ADDR_W`: source register 2 being checked.
- `rs1_busy`, output, 1: `rs1_addr` has a pending write (combinational).
- `rs2_busy`, output, 1: `rs2_addr` has a pending write (combinational).
- `rf_we`, output, 1: register bank write enable (registered).
- `rf_waddr`, output, `ADDR_W`: register bank write address (registered).
- `rf_wdata`, output, `DATA_W`: register bank write data (registered).
- `waw_error`, output, 1: sticky flag; issue targeted an already-pending register.

## Operation
- **Handshake.** A beat is accepted when `valid && ready` at a rising edge. `ready` = FIFO not full; it does not depend on `valid`. Data must be stable while `valid` is high.
- **FIFOs.** One FIFO per source, `FIFO_DEPTH` entries, circular read/write pointers plus a count.
  - Push and pop in the same cycle is legal even when the FIFO is full: `ready` is 0 that cycle, so no push actually occurs.
  - Pointers wrap modulo `FIFO_DEPTH`.
- **Arbiter.** State `last_grant` ∈ {ALU, MEM}; reset value MEM, so ALU wins the first contention.
  - Both heads valid: grant the source that is not `last_grant`.
  - One head valid: grant it.
  - `last_grant` updates on every grant.
- **Grant.** The granted head is popped. Output registers load `rf_waddr <= head.rd`, `rf_wdata <= head.data`, `rf_we <= (head.rd != 0)`.
  - A beat with rd = 0 is consumed but never written.
  - With no grant, `rf_we <= 0` and `rf_waddr`/`rf_wdata` hold.
- **Scoreboard.** `pending[31:0]`, one bit per register.
  - Set on `issue_valid` when `issue_rd != 0`.
  - Cleared at the edge where `rf_we` = 1 for `rf_waddr`.
  - Same register set and cleared in the same cycle: set wins.
  - `pending[0]` is constant 0.
  - `rsN_busy = pending[rsN_addr]`.
- **waw_error.** Set when `issue_valid` targets a register whose pending bit is 1 and is not being cleared that cycle. Cleared only by reset.

## Timing
- Reset (asynchronous, takes effect immediately on `rst_n` low):
  - `rf_we`=0, `rf_waddr`=0, `rf_wdata`=0.
  - Both FIFOs empty, so `alu_ready` = `mem_ready` = 1.
  - `pending` = 0, `waw_error` = 0, `last_grant` = MEM.
  - All buffered beats are discarded.
- Latency:
  - A beat accepted at edge N is a FIFO head during cycle N+1.
  - If granted, `rf_we` is high during cycle N+2 and the register bank commits at edge N+3.
  - The pending bit clears at that same edge.
- Throughput: one register-file write per cycle sustained. Two sources saturating alternate writes.
- Busy outputs reflect a pending bit the cycle after it is set. They drop the cycle after the edge where the write commits, so a read in that cycle sees the new bank data.
- Full FIFO: `ready` goes low the cycle after the accepting edge that fills it. It returns high the cycle after a pop.

## Test plan
- **Reset.** Drive `rst_n`=0 mid-stream with both FIFOs holding beats → outputs zero immediately, both `ready` = 1, no `rf_we` after release.
- **Single ALU beat.** ALU beat rd=5, data=0xDEADBEEF, accepted at edge 0 → `rf_we`=1, `rf_waddr`=5, `rf_wdata`=0xDEADBEEF during cycle 2 only.
- **Contention.** Both sources push continuously (ALU rd=1,2,3; MEM rd=10,11,12) → writes ordered 1,10,2,11,3,12. Neither `ready` stays low for more than 1 cycle.
- **Backpressure.** Push 3 beats to MEM back-to-back while the ALU streams → `mem_ready` drops after the 2nd accept (`FIFO_DEPTH`=2). No beat is lost or duplicated.
- **Scoreboard.**
  - `issue_rd`=7 → `rs1_busy`=1 for `rs1_addr`=7 until the cycle after the rd=7 commit.
  - `issue_rd`=0 → busy never asserts.
  - A beat with rd=0 produces no `rf_we`.
- **Hazards.** Issue rd=9 twice without an intervening commit → `waw_error`=1 and stays 1. Issue rd=9 in the same cycle its write commits → `pending[9]` remains 1 and `waw_error` stays 0.

Source files
------------

// File: rtl/regfile_wb_arbiter_if.sv
// ---------------------------------------------------------------------------
// regfile_wb_arbiter_if
// Bundles every non-clock signal of the register-bank write-port arbiter.
//   ALU writeback  : alu_valid/alu_rd/alu_data in, alu_ready out
//   MEM writeback  : mem_valid/mem_rd/mem_data in, mem_ready out
//   Issue/hazard   : issue_valid/issue_rd, rs1_addr/rs2_addr in,
//                    rs1_busy/rs2_busy out
//   Bank write port: rf_we/rf_waddr/rf_wdata out, waw_error out
// The master modport is the surrounding pipeline; the slave modport is the
// arbiter itself.
// ---------------------------------------------------------------------------
interface regfile_wb_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              alu_valid;
  logic              alu_ready;
  logic [ADDR_W-1:0] alu_rd;
  logic [DATA_W-1:0] alu_data;

  logic              mem_valid;
  logic              mem_ready;
  logic [ADDR_W-1:0] mem_rd;
  logic [DATA_W-1:0] mem_data;

  logic              issue_valid;
  logic [ADDR_W-1:0] issue_rd;
  logic [ADDR_W-1:0] rs1_addr;
  logic [ADDR_W-1:0] rs2_addr;
  logic              rs1_busy;
  logic              rs2_busy;

  logic              rf_we;
  logic [ADDR_W-1:0] rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic              waw_error;

  modport master (
    output alu_valid, alu_rd, alu_data,
    output mem_valid, mem_rd, mem_data,
    output issue_valid, issue_rd, rs1_addr, rs2_addr,
    input  alu_ready, mem_ready, rs1_busy, rs2_busy,
    input  rf_we, rf_waddr, rf_wdata, waw_error
  );

  modport slave (
    input  alu_valid, alu_rd, alu_data,
    input  mem_valid, mem_rd, mem_data,
    input  issue_valid, issue_rd, rs1_addr, rs2_addr,
    output alu_ready, mem_ready, rs1_busy, rs2_busy,
    output rf_we, rf_waddr, rf_wdata, waw_error
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// ---------------------------------------------------------------------------
// regfile_wb_arbiter
// Buffers writeback beats from the ALU and load paths in one small FIFO each,
// round-robins the FIFO heads onto the single register-bank write port and
// keeps a per-register pending scoreboard for RAW stalls and WAW detection.
// Ports:
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset
//   bus   - regfile_wb_arbiter_if.slave (handshakes, scoreboard, write port)
// ---------------------------------------------------------------------------
module regfile_wb_arbiter #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 5,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  regfile_wb_arbiter_if.slave   bus
);
  localparam int NREG  = 1 << ADDR_W;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  typedef enum logic {
    GRANT_ALU = 1'b0,
    GRANT_MEM = 1'b1
  } grant_e;

  // Source 0 is the ALU path, source 1 the load path.
  logic [1:0]        in_valid;
  logic [1:0]        in_ready;
  logic [1:0]        head_valid;
  logic [1:0]        pop;
  logic [ADDR_W-1:0] in_rd     [2];
  logic [DATA_W-1:0] in_data   [2];
  logic [ADDR_W-1:0] head_rd   [2];
  logic [DATA_W-1:0] head_data [2];

  assign in_valid   = {bus.mem_valid, bus.alu_valid};
  assign in_rd[0]   = bus.alu_rd;
  assign in_rd[1]   = bus.mem_rd;
  assign in_data[0] = bus.alu_data;
  assign in_data[1] = bus.mem_data;

  assign bus.alu_ready = in_ready[0];
  assign bus.mem_ready = in_ready[1];

  genvar gi;

  // -------------------------------------------------------------------------
  // Per-source FIFOs: circular pointers plus an occupancy count. Ready only
  // looks at the count, so a pop while full does not admit a push that cycle.
  // -------------------------------------------------------------------------
  generate
    for (gi = 0; gi < 2; gi++) begin : g_fifo
      logic [ADDR_W-1:0] rd_mem_q   [FIFO_DEPTH];
      logic [DATA_W-1:0] data_mem_q [FIFO_DEPTH];
      logic [PTR_W-1:0]  wptr_q, wptr_d;
      logic [PTR_W-1:0]  rptr_q, rptr_d;
      logic [CNT_W-1:0]  count_q, count_d;
      logic              push;

      assign in_ready[gi]   = (count_q != CNT_W'(FIFO_DEPTH));
      assign head_valid[gi] = (count_q != '0);
      assign push           = in_valid[gi] & in_ready[gi];
      assign head_rd[gi]    = rd_mem_q[rptr_q];
      assign head_data[gi]  = data_mem_q[rptr_q];

      // Power-of-two depth lets the pointers wrap by plain overflow.
      always_comb begin
        wptr_d  = push ? wptr_q + 1'b1 : wptr_q;
        rptr_d  = pop[gi] ? rptr_q + 1'b1 : rptr_q;
        count_d = count_q + CNT_W'(push) - CNT_W'(pop[gi]);
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          wptr_q  <= '0;
          rptr_q  <= '0;
          count_q <= '0;
        end else begin
          wptr_q  <= wptr_d;
          rptr_q  <= rptr_d;
          count_q <= count_d;
        end
      end

      // Storage needs no reset: the count gates every read of it.
      always_ff @(posedge clk) begin
        if (push) begin
          rd_mem_q[wptr_q]   <= in_rd[gi];
          data_mem_q[wptr_q] <= in_data[gi];
        end
      end
    end
  endgenerate

  // -------------------------------------------------------------------------
  // Round-robin arbiter and registered write port.
  // -------------------------------------------------------------------------
  grant_e            last_grant_q, last_grant_d;
  logic              grant_alu, grant_mem;
  logic              rf_we_q, rf_we_d;
  logic [ADDR_W-1:0] rf_waddr_q, rf_waddr_d;
  logic [DATA_W-1:0] rf_wdata_q, rf_wdata_d;

  always_comb begin
    // On contention the source that did not win last time goes first.
    grant_alu    = head_valid[0] && (!head_valid[1] || last_grant_q == GRANT_MEM);
    grant_mem    = head_valid[1] && !grant_alu;
    pop          = {grant_mem, grant_alu};
    last_grant_d = last_grant_q;
    rf_we_d      = 1'b0;
    rf_waddr_d   = rf_waddr_q;
    rf_wdata_d   = rf_wdata_q;
    if (grant_alu) begin
      last_grant_d = GRANT_ALU;
      rf_we_d      = (head_rd[0] != '0);
      rf_waddr_d   = head_rd[0];
      rf_wdata_d   = head_data[0];
    end else if (grant_mem) begin
      last_grant_d = GRANT_MEM;
      rf_we_d      = (head_rd[1] != '0);
      rf_waddr_d   = head_rd[1];
      rf_wdata_d   = head_data[1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_q <= GRANT_MEM;
      rf_we_q      <= 1'b0;
      rf_waddr_q   <= '0;
      rf_wdata_q   <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      rf_we_q      <= rf_we_d;
      rf_waddr_q   <= rf_waddr_d;
      rf_wdata_q   <= rf_wdata_d;
    end
  end

  assign bus.rf_we    = rf_we_q;
  assign bus.rf_waddr = rf_waddr_q;
  assign bus.rf_wdata = rf_wdata_q;

  // -------------------------------------------------------------------------
  // Pending scoreboard. A bit clears on the edge that commits its write and
  // a same-cycle issue to that register re-sets it (set has priority).
  // -------------------------------------------------------------------------
  logic [NREG-1:0] pending_q, pending_d;
  logic            waw_error_q, waw_error_d;
  logic            waw_hit;

  assign pending_d[0] = 1'b0;

  generate
    for (gi = 1; gi < NREG; gi++) begin : g_pending
      logic set_bit, clr_bit;
      assign set_bit       = bus.issue_valid && (bus.issue_rd == ADDR_W'(gi));
      assign clr_bit       = rf_we_q && (rf_waddr_q == ADDR_W'(gi));
      assign pending_d[gi] = set_bit | (pending_q[gi] & ~clr_bit);
    end
  endgenerate

  // pending_q[0] is always 0, so issue_rd == 0 can never raise the flag.
  assign waw_hit     = bus.issue_valid && pending_q[bus.issue_rd] &&
                       !(rf_we_q && rf_waddr_q == bus.issue_rd);
  assign waw_error_d = waw_error_q | waw_hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q   <= '0;
      waw_error_q <= 1'b0;
    end else begin
      pending_q   <= pending_d;
      waw_error_q <= waw_error_d;
    end
  end

  assign bus.rs1_busy  = pending_q[bus.rs1_addr];
  assign bus.rs2_busy  = pending_q[bus.rs2_addr];
  assign bus.waw_error = waw_error_q;

endmodule
